// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF spike monitor.
// The record struct describes one window result at the default widths.
package lif_pkg;

   localparam int STATE_W   = 8;
   localparam int CNT_W_DEF = 8;
   localparam int ISI_W_DEF = 12;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } lif_state_e;

   typedef struct packed {
      logic [CNT_W_DEF-1:0] count;
      logic [STATE_W-1:0]   vmax;
      logic [ISI_W_DEF-1:0] isi;
      logic                 overrun;
   } lif_rec_t;

   function automatic logic [STATE_W-1:0] umax(input logic [STATE_W-1:0] a,
                                                input logic [STATE_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lif_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// q_inc is the saturated q+inc value, exposed so callers can snapshot it.
module lif_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic [W-1:0] q_inc
);

   localparam logic [W-1:0] MAX = '1;

   assign q_inc = (inc && (q != MAX)) ? q + W'(1) : q;

   always_ff @(posedge clk) begin
      if (rst || clr) q <= '0;
      else            q <= q_inc;
   end

endmodule

// File: rtl/lif_spike_monitor.sv
// Windowed spike statistics (count, peak state, last ISI) for a LIF neuron,
// delivered as one record per window over a valid/ready handshake.
module lif_spike_monitor
   import lif_pkg::*;
#(
   parameter int WIN_W = 16,
   parameter int CNT_W = 8,
   parameter int ISI_W = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [WIN_W-1:0]   win_len,
   input  logic               spike_in,
   input  logic [STATE_W-1:0] state_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CNT_W-1:0]   out_count,
   output logic [STATE_W-1:0] out_vmax,
   output logic [ISI_W-1:0]   out_isi,
   output logic               out_overrun,
   output logic               busy
);

   lif_state_e state, state_nxt;

   logic               active, close, spike_act, hs;
   logic               seen, drop;
   logic [WIN_W-1:0]   len_q, len_eff, wcnt, wcnt_inc;
   logic [CNT_W-1:0]   cnt, cnt_inc;
   logic [ISI_W-1:0]   gap, gap_inc, isi_last, isi_snap;
   logic [STATE_W-1:0] vmax, vmax_snap;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en)  state_nxt = RUN;
         RUN:     if (!en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // en low while in RUN discards the cycle: nothing is sampled and no window closes.
   assign busy      = (state == RUN);
   assign active    = busy & en;
   assign spike_act = active & spike_in;
   assign hs        = out_valid & out_ready;
   assign len_eff   = (win_len == '0) ? WIN_W'(1) : win_len;
   assign close     = active && (wcnt_inc == len_q);

   always_ff @(posedge clk) begin
      if (rst)                              len_q <= '0;
      else if ((!busy && en) || close)      len_q <= len_eff;
   end

   lif_sat_counter #(.W(WIN_W)) u_win (
      .clk   (clk),
      .rst   (rst),
      .clr   (~active | close),
      .inc   (active),
      .q     (wcnt),
      .q_inc (wcnt_inc)
   );

   lif_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (~active | close),
      .inc   (spike_act),
      .q     (cnt),
      .q_inc (cnt_inc)
   );

   // gap_inc on a spike cycle is the saturated distance from the previous spike.
   lif_sat_counter #(.W(ISI_W)) u_gap (
      .clk   (clk),
      .rst   (rst),
      .clr   (spike_act),
      .inc   (active),
      .q     (gap),
      .q_inc (gap_inc)
   );

   assign vmax_snap = umax(vmax, state_in);
   assign isi_snap  = (spike_act && seen) ? gap_inc : isi_last;

   always_ff @(posedge clk) begin
      if (rst || !active || close) vmax <= '0;
      else                         vmax <= vmax_snap;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seen     <= 1'b0;
         isi_last <= '0;
      end else begin
         if (!busy)          seen <= 1'b0;
         else if (spike_act) seen <= 1'b1;
         isi_last <= isi_snap;
      end
   end

   // A close while the old record is stalled drops the new one and remembers it.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_count   <= '0;
         out_vmax    <= '0;
         out_isi     <= '0;
         out_overrun <= 1'b0;
         drop        <= 1'b0;
      end else if (close) begin
         if (!out_valid || out_ready) begin
            out_valid   <= 1'b1;
            out_count   <= cnt_inc;
            out_vmax    <= vmax_snap;
            out_isi     <= isi_snap;
            out_overrun <= drop;
            drop        <= 1'b0;
         end else begin
            drop <= 1'b1;
         end
      end else if (hs) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Self-checking bench for lif_spike_monitor: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_lif_spike_monitor;
   import lif_pkg::*;

   logic        clk = 1'b0;
   logic        rst, en, spike_in, out_ready;
   logic [15:0] win_len;
   logic [7:0]  state_in;
   logic        out_valid, out_overrun, busy;
   logic [7:0]  out_count, out_vmax;
   logic [11:0] out_isi;

   int  checks = 0;
   int  errors = 0;
   bit  cmp_on = 1'b0;
   bit  rnd    = 1'b0;

   lif_spike_monitor #(.WIN_W(16), .CNT_W(8), .ISI_W(12)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .win_len     (win_len),
      .spike_in    (spike_in),
      .state_in    (state_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_count   (out_count),
      .out_vmax    (out_vmax),
      .out_isi     (out_isi),
      .out_overrun (out_overrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: window position, counts and absolute spike times.
   bit       m_run, m_seen, m_valid, m_drop;
   int       m_len, m_pos, m_cnt, m_vmax, m_isi;
   longint   m_last, cyc;
   lif_rec_t m_rec;

   always @(posedge clk) begin : model
      bit hs;
      hs = m_valid && out_ready;
      if (rst) begin
         m_run = 0; m_seen = 0; m_valid = 0; m_drop = 0;
         m_len = 0; m_pos = 0; m_cnt = 0; m_vmax = 0; m_isi = 0;
         m_rec = '0;
      end else if (!m_run) begin
         m_seen = 0;
         if (hs) m_valid = 0;
         if (en) begin
            m_run = 1; m_pos = 0; m_cnt = 0; m_vmax = 0;
            m_len = (win_len == 0) ? 1 : int'(win_len);
         end
      end else if (!en) begin
         m_run = 0; m_seen = 0;
         if (hs) m_valid = 0;
      end else begin
         if (spike_in) begin
            if (m_cnt < 255) m_cnt++;
            if (m_seen) m_isi = (cyc - m_last > 4095) ? 4095 : int'(cyc - m_last);
            m_seen = 1;
            m_last = cyc;
         end
         if (int'(state_in) > m_vmax) m_vmax = int'(state_in);
         if (m_pos == m_len - 1) begin
            if (!m_valid || out_ready) begin
               m_rec.count   = 8'(m_cnt);
               m_rec.vmax    = 8'(m_vmax);
               m_rec.isi     = 12'(m_isi);
               m_rec.overrun = m_drop;
               m_drop  = 0;
               m_valid = 1;
            end else begin
               m_drop = 1;
            end
            m_pos = 0; m_cnt = 0; m_vmax = 0;
            m_len = (win_len == 0) ? 1 : int'(win_len);
         end else begin
            m_pos++;
            if (hs) m_valid = 0;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("cmp_busy", busy, m_run);
         chk("cmp_valid", out_valid, m_valid);
         if (m_valid) begin
            chk("cmp_count", out_count, m_rec.count);
            chk("cmp_vmax", out_vmax, m_rec.vmax);
            chk("cmp_isi", out_isi, m_rec.isi);
            chk("cmp_overrun", out_overrun, m_rec.overrun);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (rnd) begin
            spike_in = 1'($urandom_range(0, 1));
            state_in = 8'($urandom_range(0, 255));
         end
      end
   endtask

   task automatic wait_valid(input string nm, input int bound);
      int n = 0;
      while (out_valid !== 1'b1 && n < bound) begin
         tick(1);
         n++;
      end
      chk(nm, out_valid, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  c0, v0;
      logic [11:0] i0;
      rst = 1; en = 0; win_len = 0; spike_in = 0; state_in = 0; out_ready = 0;
      tick(2);
      rst = 0;
      cmp_on = 1;
      chk("rst_valid", out_valid, 0);
      chk("rst_count", out_count, 0);
      chk("rst_vmax", out_vmax, 0);
      chk("rst_isi", out_isi, 0);
      chk("rst_overrun", out_overrun, 0);
      for (int i = 0; i < 50; i++) begin
         tick(1);
         chk("idle_valid", out_valid, 0);
         chk("idle_busy", busy, 0);
      end

      // Basic window: spikes at 2 and 7, ramp 0..9.
      out_ready = 1; win_len = 10; en = 1;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         spike_in = (k == 2 || k == 7);
         state_in = 8'(k);
      end
      tick(1);
      spike_in = 0; state_in = 0;
      chk("basic_valid", out_valid, 1);
      chk("basic_count", out_count, 2);
      chk("basic_vmax", out_vmax, 9);
      chk("basic_isi", out_isi, 5);
      chk("basic_overrun", out_overrun, 0);
      chk("basic_nogap_busy", busy, 1);
      en = 0;
      tick(2);

      // Count saturation, then ISI saturation.
      win_len = 300; spike_in = 1; state_in = 200; en = 1;
      tick(301);
      chk("sat_valid", out_valid, 1);
      chk("sat_count", out_count, 255);
      chk("sat_vmax", out_vmax, 200);
      chk("sat_isi1", out_isi, 1);
      spike_in = 0; state_in = 0; win_len = 0;
      tick(5000);
      spike_in = 1;
      tick(1);
      spike_in = 0;
      chk("isi_sat_valid", out_valid, 1);
      chk("isi_sat", out_isi, 4095);
      chk("isi_sat_count", out_count, 1);
      en = 0;
      tick(2);

      // Backpressure: 12 stalled run cycles, two drops.
      rnd = 1; out_ready = 0; win_len = 4; en = 1;
      tick(5);
      chk("bp_first_valid", out_valid, 1);
      c0 = out_count; v0 = out_vmax; i0 = out_isi;
      tick(8);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_count", out_count, c0);
      chk("bp_hold_vmax", out_vmax, v0);
      chk("bp_hold_isi", out_isi, i0);
      out_ready = 1;
      tick(1);
      wait_valid("bp_wait1", 10);
      chk("bp_overrun1", out_overrun, 1);
      tick(1);
      wait_valid("bp_wait2", 10);
      chk("bp_overrun0", out_overrun, 0);
      en = 0;
      tick(2);

      // win_len=0: one record per cycle, close-cycle spike counted, no bubbles.
      rnd = 0; win_len = 0; out_ready = 1; en = 1; spike_in = 0;
      tick(1);
      spike_in = 1; state_in = 7;
      tick(1);
      chk("w0_valid", out_valid, 1);
      chk("w0_count1", out_count, 1);
      chk("w0_vmax", out_vmax, 7);
      spike_in = 0; state_in = 3;
      tick(1);
      chk("w0_count0", out_count, 0);
      chk("w0_vmax3", out_vmax, 3);
      rnd = 1;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk("w0_nobubble", out_valid, 1);
      end
      rnd = 0; en = 0; spike_in = 0; state_in = 0;
      tick(2);

      // Abort with a pending record; seen flag must clear.
      out_ready = 0; win_len = 20; en = 1;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         spike_in = (k == 2 || k == 6);
      end
      tick(1);
      spike_in = 0;
      chk("ab_valid", out_valid, 1);
      chk("ab_count", out_count, 2);
      chk("ab_isi", out_isi, 4);
      tick(5);
      en = 0;
      tick(1);
      chk("ab_busy", busy, 0);
      chk("ab_pending", out_valid, 1);
      out_ready = 1;
      tick(1);
      chk("ab_delivered", out_valid, 0);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("ab_no_partial", out_valid, 0);
      end
      win_len = 10; en = 1;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         spike_in = (k == 3);
      end
      tick(1);
      spike_in = 0;
      chk("re_valid", out_valid, 1);
      chk("re_count", out_count, 1);
      chk("re_isi_kept", out_isi, 4);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 499) == 0);
         en        = ($urandom_range(0, 15) != 0);
         win_len   = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 40))
                                                 : 16'($urandom_range(0, 6));
         out_ready = ($urandom_range(0, 3) != 0);
         spike_in  = ($urandom_range(0, 2) == 0);
         state_in  = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
